// File: rtl/int_ctrl_multi.sv
// Fixed-priority interrupt controller: NUM_IRQ maskable level/edge channels plus an optional NMI.
// The NMI path is built only when INTC_NMI_EN is defined; otherwise nmi_in is ignored.
module int_ctrl_multi #(
  parameter int                   NUM_IRQ  = 8,
  parameter int                   IDX_W    = 3,
  parameter logic [NUM_IRQ-1:0]   EDGE_SEL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               nmi_in,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               fetch_boundary,
  input  logic               int_ack,
  input  logic               int_done,
  output logic               int_req,
  output logic               int_is_nmi,
  output logic [IDX_W-1:0]   int_idx,
  output logic [NUM_IRQ-1:0] pending_q,
  output logic [NUM_IRQ-1:0] mask_q,
  output logic               in_service
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SVC  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_IRQ-1:0] irq_s_q, irq_d_q, pending_d, pend_clr;
  logic               int_req_d, int_is_nmi_d, in_service_d;
  logic [IDX_W-1:0]   int_idx_d;
  logic               nmi_pend;
  logic               cand_vld, cand_nmi;
  logic [IDX_W-1:0]   cand_idx;
  logic               ack_evt;

  assign ack_evt = (state_q == S_REQ) && int_ack;

`ifdef INTC_NMI_EN
  logic nmi_s_q, nmi_d_q, nmi_pend_q;
  logic nmi_clr;

  // A fresh edge wins over a simultaneous ack so the NMI is never lost.
  assign nmi_clr = ack_evt && int_is_nmi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_s_q    <= 1'b0;
      nmi_d_q    <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_s_q    <= nmi_in;
      nmi_d_q    <= nmi_s_q;
      nmi_pend_q <= (nmi_pend_q & ~nmi_clr) | (nmi_s_q & ~nmi_d_q);
    end
  end

  assign nmi_pend = nmi_pend_q;
`else
  logic nmi_unused;
  assign nmi_unused = nmi_in;
  assign nmi_pend   = 1'b0;
`endif

  // Level channels mirror the synchronised line; edge channels latch until acked.
  always_comb begin
    pend_clr  = '0;
    pending_d = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      pend_clr[i]  = ack_evt && !int_is_nmi && (int_idx == IDX_W'(i));
      pending_d[i] = EDGE_SEL[i]
                   ? ((pending_q[i] & ~pend_clr[i]) | (irq_s_q[i] & ~irq_d_q[i]))
                   : irq_s_q[i];
    end
  end

  // Descending scan so the lowest enabled index is the one left standing.
  always_comb begin
    cand_vld = nmi_pend;
    cand_nmi = nmi_pend;
    cand_idx = '0;
    if (!nmi_pend) begin
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
        if (pending_q[i] && mask_q[i]) begin
          cand_vld = 1'b1;
          cand_idx = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req;
    int_is_nmi_d = int_is_nmi;
    int_idx_d    = int_idx;
    in_service_d = in_service;
    case (state_q)
      S_IDLE: begin
        if (fetch_boundary && cand_vld) begin
          int_req_d    = 1'b1;
          int_is_nmi_d = cand_nmi;
          int_idx_d    = cand_idx;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
          state_d      = S_SVC;
        end
      end
      S_SVC: begin
        if (int_done) begin
          in_service_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      irq_s_q    <= '0;
      irq_d_q    <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      int_req    <= 1'b0;
      int_is_nmi <= 1'b0;
      int_idx    <= '0;
      in_service <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_s_q    <= irq_in;
      irq_d_q    <= irq_s_q;
      pending_q  <= pending_d;
      if (mask_wr) mask_q <= mask_wdata;
      int_req    <= int_req_d;
      int_is_nmi <= int_is_nmi_d;
      int_idx    <= int_idx_d;
      in_service <= in_service_d;
    end
  end

endmodule

// File: tb/tb_int_ctrl_multi.sv
// Directed bench for int_ctrl_multi: channels 3 and 5 are edge-triggered, the rest level.
module tb_int_ctrl_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] irq_in = '0;
  logic       nmi_in = 1'b0;
  logic       mask_wr = 1'b0;
  logic [7:0] mask_wdata = '0;
  logic       fetch_boundary = 1'b1;
  logic       int_ack = 1'b0;
  logic       int_done = 1'b0;
  logic       int_req, int_is_nmi, in_service;
  logic [2:0] int_idx;
  logic [7:0] pending_q, mask_q;

  int checks = 0;
  int errors = 0;

`ifdef INTC_NMI_EN
  localparam logic NMI_ON = 1'b1;
`else
  localparam logic NMI_ON = 1'b0;
`endif

  int_ctrl_multi #(.NUM_IRQ(8), .IDX_W(3), .EDGE_SEL(8'b0010_1000)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .nmi_in(nmi_in),
    .mask_wr(mask_wr), .mask_wdata(mask_wdata), .fetch_boundary(fetch_boundary),
    .int_ack(int_ack), .int_done(int_done), .int_req(int_req),
    .int_is_nmi(int_is_nmi), .int_idx(int_idx), .pending_q(pending_q),
    .mask_q(mask_q), .in_service(in_service)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] irq;
    logic       mwr;
    logic [7:0] mdat;
    logic       fb, ack, done;
    logic       exp_req;
    logic [2:0] exp_idx;
    logic       exp_svc;
    logic [7:0] exp_pend;
    logic [7:0] exp_mask;
  } vec_t;

  vec_t vt [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    //               irq    mwr  mdat   fb  ack done req idx svc  pend   mask
    vt[0] = '{8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF};
    vt[1] = '{8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF};
    vt[2] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h20, 8'hFF};
    vt[3] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 8'h20, 8'hFF};
    vt[4] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 8'hFF};
    vt[5] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 8'hFF};
    vt[6] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF};
    vt[7] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF};

    #1 rst = 1'b1;
    #3;
    chk("rst_req", int_req, 0);
    chk("rst_svc", in_service, 0);
    chk("rst_mask", mask_q, 0);
    chk("rst_pend", pending_q, 0);
    chk("rst_nmi", int_is_nmi, 0);
    chk("rst_idx", int_idx, 0);
    tick();
    rst = 1'b0;

    // Edge IRQ on channel 5, table-driven
    for (int i = 0; i < 8; i++) begin
      irq_in = vt[i].irq; mask_wr = vt[i].mwr; mask_wdata = vt[i].mdat;
      fetch_boundary = vt[i].fb; int_ack = vt[i].ack; int_done = vt[i].done;
      tick();
      chk($sformatf("tbl%0d_req", i), int_req, vt[i].exp_req);
      if (vt[i].exp_req) chk($sformatf("tbl%0d_idx", i), int_idx, vt[i].exp_idx);
      chk($sformatf("tbl%0d_svc", i), in_service, vt[i].exp_svc);
      chk($sformatf("tbl%0d_pend", i), pending_q, vt[i].exp_pend);
      chk($sformatf("tbl%0d_mask", i), mask_q, vt[i].exp_mask);
    end
    int_done = 1'b0;

    // Priority and freeze with level channels 2 and 6
    irq_in = 8'h44;
    tick(); tick();
    chk("prio_pend", pending_q, 8'h44);
    chk("prio_req0", int_req, 0);
    tick();
    chk("prio_req", int_req, 1);
    chk("prio_idx", int_idx, 2);
    irq_in = 8'h45;
    tick(); tick(); tick();
    chk("freeze_req", int_req, 1);
    chk("freeze_idx", int_idx, 2);
    chk("freeze_pend", pending_q, 8'h45);
    int_ack = 1'b1; irq_in = 8'h00;
    tick();
    chk("prio_ack_svc", in_service, 1);
    chk("prio_ack_req", int_req, 0);
    int_ack = 1'b0;
    tick();
    chk("level_drop_pend", pending_q, 8'h00);
    int_done = 1'b1;
    tick();
    chk("prio_done_svc", in_service, 0);
    int_done = 1'b0;
    tick();
    chk("prio_idle_req", int_req, 0);

    // Masking
    mask_wr = 1'b1; mask_wdata = 8'h00;
    tick();
    mask_wr = 1'b0; irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    tick();
    chk("mask_pend", pending_q, 8'h08);
    tick(); tick();
    chk("mask_blocked_req", int_req, 0);
    mask_wr = 1'b1; mask_wdata = 8'h08;
    tick();
    chk("mask_load", mask_q, 8'h08);
    chk("mask_load_req", int_req, 0);
    mask_wr = 1'b0;
    tick();
    chk("mask_req", int_req, 1);
    chk("mask_idx", int_idx, 3);
    int_ack = 1'b1;
    tick();
    chk("mask_ack_pend", pending_q, 8'h00);
    chk("mask_ack_svc", in_service, 1);
    int_ack = 1'b0; int_done = 1'b1;
    tick();
    int_done = 1'b0;

    // NMI preference and NMI held during service
    mask_wr = 1'b1; mask_wdata = 8'h01;
    tick();
    mask_wr = 1'b0; nmi_in = 1'b1; irq_in = 8'h01;
    tick();
    nmi_in = 1'b0;
    tick(); tick();
    chk("nmi_req", int_req, 1);
    chk("nmi_is", int_is_nmi, NMI_ON);
    chk("nmi_idx", int_idx, 0);
    int_ack = 1'b1;
    tick();
    chk("nmi_svc", in_service, 1);
    int_ack = 1'b0; int_done = 1'b1;
    tick();
    int_done = 1'b0;
    tick();
    chk("after_nmi_req", int_req, 1);
    chk("after_nmi_is", int_is_nmi, 0);
    chk("after_nmi_idx", int_idx, 0);
    irq_in = 8'h00; int_ack = 1'b1;
    tick();
    int_ack = 1'b0; nmi_in = 1'b1;
    tick();
    nmi_in = 1'b0;
    tick(); tick(); tick();
    chk("nmi_held_req", int_req, 0);
    chk("nmi_held_svc", in_service, 1);
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
    tick();
    chk("nmi_late_req", int_req, NMI_ON);
    chk("nmi_late_is", int_is_nmi, NMI_ON);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0; int_done = 1'b1;
    tick();
    int_done = 1'b0;
    tick();
    chk("nmi_clean_req", int_req, 0);
    chk("nmi_clean_svc", in_service, 0);

    // Fetch-boundary gating
    mask_wr = 1'b1; mask_wdata = 8'hFF; fetch_boundary = 1'b0;
    tick();
    mask_wr = 1'b0; irq_in = 8'h20;
    tick();
    irq_in = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("gate%0d_req", i), int_req, 0);
    end
    fetch_boundary = 1'b1;
    tick();
    chk("gate_open_req", int_req, 1);
    chk("gate_open_idx", int_idx, 5);

    // Reset in SERVICE with another edge latched
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0; irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    tick();
    chk("pre_rst_pend", pending_q, 8'h08);
    chk("pre_rst_svc", in_service, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", int_req, 0);
    chk("arst_svc", in_service, 0);
    chk("arst_mask", mask_q, 0);
    chk("arst_pend", pending_q, 0);
    tick();
    rst = 1'b0;
    mask_wr = 1'b1; mask_wdata = 8'hFF;
    tick();
    mask_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst%0d_req", i), int_req, 0);
    end
    chk("post_rst_pend", pending_q, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
